// File: rtl/rx_lp_seq_detector_if.sv
// LP line levels and enable toward the detector, plus the state and event outputs it returns.
interface rx_lp_seq_detector_if;
  logic       A;
  logic       B;
  logic       C;
  logic       En;
  logic [3:0] State;
  logic [1:0] CtrlCode;
  logic       RxStop;
  logic       HsEntry;
  logic       TaEntry;
  logic       EscEntry;
  logic       ErrPulse;

  modport master (
    output A, B, C, En,
    input  State, CtrlCode, RxStop, HsEntry, TaEntry, EscEntry, ErrPulse
  );

  modport slave (
    input  A, B, C, En,
    output State, CtrlCode, RxStop, HsEntry, TaEntry, EscEntry, ErrPulse
  );
endinterface

// File: rtl/rx_lp_seq_detector.sv
// LP line sequence detector: synchronises and deglitches the {A,B,C} code, then tracks
// the HS / turnaround / escape entry sequences with a dwell timeout on transient states.
module rx_lp_seq_detector #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rx_lp_seq_detector_if.slave  lp
);

  localparam int              TW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [7:0]      FILT_MAX = 8'(FILTER_CYCLES);
  localparam logic [TW-1:0]   TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    ST_STOP     = 4'd0,
    ST_HS_RQST  = 4'd1,
    ST_HS       = 4'd2,
    ST_LP_RQST  = 4'd3,
    ST_LP_YIELD = 4'd4,
    ST_TA_RQST  = 4'd5,
    ST_TA       = 4'd6,
    ST_ESC_RQST = 4'd7,
    ST_ESC      = 4'd8,
    ST_ERR      = 4'd9
  } state_e;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v >= FILT_MAX) ? FILT_MAX : v + 8'd1;
  endfunction

  function automatic logic [1:0] decode(input logic [2:0] code);
    case (code)
      3'b111:  return 2'b00;
      3'b001:  return 2'b01;
      3'b000:  return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  // Stage p0: synchroniser chain, keeps sampling regardless of En
  logic [2:0] sync_p0 [SYNC_STAGES];
  logic [2:0] s_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p0[i] <= 3'b000;
    end else begin
      sync_p0[0] <= {lp.A, lp.B, lp.C};
      for (int i = 1; i < SYNC_STAGES; i++) sync_p0[i] <= sync_p0[i-1];
    end
  end

  assign s_p0 = sync_p0[SYNC_STAGES-1];

  // Stage p1/p2: run-length filter; a zero count means the filter restarts from S
  logic [2:0] cand_p1;
  logic [7:0] cnt_p1;
  logic [2:0] acc_p1;
  logic       vld_p2;
  logic       filt_new;
  logic [7:0] cnt_nxt;
  logic       accept;

  always_comb begin
    filt_new = (cnt_p1 == 8'd0) || (s_p0 != cand_p1);
    cnt_nxt  = filt_new ? 8'd1 : sat_inc(cnt_p1);
    accept   = (cnt_nxt == FILT_MAX) && (filt_new || (cnt_p1 != FILT_MAX));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_p1 <= 3'b000;
      cnt_p1  <= 8'd0;
      acc_p1  <= 3'b111;
      vld_p2  <= 1'b0;
    end else if (!lp.En) begin
      cand_p1 <= s_p0;
      cnt_p1  <= 8'd0;
      acc_p1  <= 3'b111;
      vld_p2  <= 1'b0;
    end else begin
      cand_p1 <= s_p0;
      cnt_p1  <= cnt_nxt;
      if (accept) acc_p1 <= s_p0;
      // Re-accepting the code already held is not a change and must not move the FSM
      vld_p2  <= accept && (s_p0 != acc_p1);
    end
  end

  // Stage p3: sequence FSM and registered outputs
  state_e        state_p3, state_nxt;
  logic [TW-1:0] tcnt_p3, tcnt_nxt;
  logic [1:0]    ctrl_p3, ctrl_nxt;
  logic          rxstop_p3, rxstop_nxt;
  logic          hs_p3, ta_p3, esc_p3, err_p3;
  logic          hs_nxt, ta_nxt, esc_nxt, err_nxt;
  logic          transient;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p3  <= ST_STOP;
      tcnt_p3   <= '0;
      ctrl_p3   <= 2'b00;
      rxstop_p3 <= 1'b0;
      hs_p3     <= 1'b0;
      ta_p3     <= 1'b0;
      esc_p3    <= 1'b0;
      err_p3    <= 1'b0;
    end else begin
      state_p3  <= state_nxt;
      tcnt_p3   <= tcnt_nxt;
      ctrl_p3   <= ctrl_nxt;
      rxstop_p3 <= rxstop_nxt;
      hs_p3     <= hs_nxt;
      ta_p3     <= ta_nxt;
      esc_p3    <= esc_nxt;
      err_p3    <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state_p3;
    transient = (state_p3 == ST_HS_RQST) || (state_p3 == ST_LP_RQST) ||
                (state_p3 == ST_LP_YIELD) || (state_p3 == ST_TA_RQST) ||
                (state_p3 == ST_ESC_RQST);
    if (vld_p2) begin
      if (acc_p1 == 3'b111) begin
        state_nxt = ST_STOP;
      end else begin
        case (state_p3)
          ST_STOP:     state_nxt = (acc_p1 == 3'b001) ? ST_HS_RQST :
                                   (acc_p1 == 3'b100) ? ST_LP_RQST : ST_ERR;
          ST_HS_RQST:  state_nxt = (acc_p1 == 3'b000) ? ST_HS : ST_ERR;
          ST_LP_RQST:  state_nxt = (acc_p1 == 3'b000) ? ST_LP_YIELD : ST_ERR;
          ST_LP_YIELD: state_nxt = (acc_p1 == 3'b100) ? ST_TA_RQST :
                                   (acc_p1 == 3'b010) ? ST_ESC_RQST : ST_ERR;
          ST_TA_RQST:  state_nxt = (acc_p1 == 3'b000) ? ST_TA : ST_ERR;
          ST_ESC_RQST: state_nxt = (acc_p1 == 3'b000) ? ST_ESC : ST_ERR;
          default:     state_nxt = state_p3;
        endcase
      end
    end else if (transient && (tcnt_p3 == TO_LAST)) begin
      state_nxt = ST_ERR;
    end

    tcnt_nxt   = (transient && (state_nxt == state_p3)) ? tcnt_p3 + TW'(1) : '0;
    hs_nxt     = (state_nxt == ST_HS)  && (state_p3 != ST_HS);
    ta_nxt     = (state_nxt == ST_TA)  && (state_p3 != ST_TA);
    esc_nxt    = (state_nxt == ST_ESC) && (state_p3 != ST_ESC);
    err_nxt    = (state_nxt == ST_ERR) && (state_p3 != ST_ERR);
    ctrl_nxt   = decode(acc_p1);
    rxstop_nxt = (state_nxt == ST_STOP);

    if (!lp.En) begin
      state_nxt  = ST_STOP;
      tcnt_nxt   = '0;
      hs_nxt     = 1'b0;
      ta_nxt     = 1'b0;
      esc_nxt    = 1'b0;
      err_nxt    = 1'b0;
      ctrl_nxt   = 2'b00;
      rxstop_nxt = 1'b0;
    end
  end

  assign lp.State    = state_p3;
  assign lp.CtrlCode = ctrl_p3;
  assign lp.RxStop   = rxstop_p3;
  assign lp.HsEntry  = hs_p3;
  assign lp.TaEntry  = ta_p3;
  assign lp.EscEntry = esc_p3;
  assign lp.ErrPulse = err_p3;

endmodule
